// File: rtl/dm_responder_if.sv
// Bus bundle between the DM responder and its processor / host environment.
// The slave modport is the responder's view; master is the driving side.
interface dm_responder_if #(
  parameter int unsigned ADDR_W = 18
);
  logic [ADDR_W-1:0] dm_addr;
  logic [7:0]        dm_wdata;
  logic              dm_we;
  logic [7:0]        dm_rdata;
  logic              proc_done;
  logic              proc_rst;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              rd_last;
  logic              rd_ready;
  logic [1:0]        phase;

  modport slave (
    input  dm_addr, dm_wdata, dm_we, proc_done, ld_valid, ld_data, rd_ready,
    output dm_rdata, proc_rst, ld_ready, rd_valid, rd_data, rd_last, phase
  );

  modport master (
    output dm_addr, dm_wdata, dm_we, proc_done, ld_valid, ld_data, rd_ready,
    input  dm_rdata, proc_rst, ld_ready, rd_valid, rd_data, rd_last, phase
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: host image load, processor DM service with 1-cycle
// read latency, and streaming of the result region back to the host.
module dm_responder #(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned DEPTH    = 2 ** ADDR_W,
  parameter int unsigned LOAD_LEN = 65536,
  parameter int unsigned OUT_BASE = 65536,
  parameter int unsigned OUT_LEN  = 16384
) (
  input logic           clk,
  input logic           rst,
  dm_responder_if.slave bus
);

  typedef enum logic [1:0] {
    PhLoad = 2'd0,
    PhRun  = 2'd1,
    PhDump = 2'd2,
    PhDone = 2'd3
  } phase_e;

  logic [7:0] r_mem [DEPTH];

  phase_e            r_phase, w_phase_nxt;
  logic              r_proc_rst, w_proc_rst_nxt;
  logic              r_ld_ready, w_ld_ready_nxt;
  logic [ADDR_W-1:0] r_ld_ptr, w_ld_ptr_nxt;
  logic [ADDR_W-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic              r_rd_valid, w_rd_valid_nxt;
  logic              r_rd_last, w_rd_last_nxt;
  logic [7:0]        r_rd_data;
  logic [7:0]        r_dm_rdata;

  logic              w_ld_fire;
  logic              w_rd_fire;
  logic              w_rd_final;
  logic              w_dm_in_range;
  logic              w_rd_fetch;
  logic [ADDR_W-1:0] w_fetch_ptr;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [7:0]        w_mem_wdata;

  assign w_ld_fire     = bus.ld_valid && r_ld_ready;
  assign w_rd_fire     = r_rd_valid && bus.rd_ready;
  assign w_rd_final    = (32'(r_rd_ptr) == OUT_LEN - 1);
  assign w_dm_in_range = (32'(bus.dm_addr) < DEPTH);
  assign w_fetch_addr  = ADDR_W'(OUT_BASE) + w_fetch_ptr;

  always_comb begin
    w_phase_nxt    = r_phase;
    w_proc_rst_nxt = r_proc_rst;
    w_ld_ready_nxt = r_ld_ready;
    w_ld_ptr_nxt   = r_ld_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_rd_valid_nxt = r_rd_valid;
    w_rd_last_nxt  = r_rd_last;
    w_rd_fetch     = 1'b0;
    w_fetch_ptr    = r_rd_ptr;
    w_mem_we       = 1'b0;
    w_mem_waddr    = r_ld_ptr;
    w_mem_wdata    = bus.ld_data;

    unique case (r_phase)
      PhLoad: begin
        w_ld_ready_nxt = 1'b1;
        if (w_ld_fire) begin
          w_mem_we     = 1'b1;
          w_ld_ptr_nxt = r_ld_ptr + 1'b1;
          if (32'(r_ld_ptr) == LOAD_LEN - 1) begin
            w_phase_nxt    = PhRun;
            w_ld_ready_nxt = 1'b0;
            w_proc_rst_nxt = 1'b0;
          end
        end
      end
      PhRun: begin
        if (bus.dm_we && w_dm_in_range) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = bus.dm_addr;
          w_mem_wdata = bus.dm_wdata;
        end
        if (bus.proc_done) begin
          w_phase_nxt    = PhDump;
          w_proc_rst_nxt = 1'b1;
          w_rd_ptr_nxt   = '0;
        end
      end
      PhDump: begin
        // rd_valid is low in DUMP only before the first byte has been fetched.
        if (!r_rd_valid) begin
          w_rd_fetch     = 1'b1;
          w_rd_valid_nxt = 1'b1;
          w_rd_last_nxt  = w_rd_final;
        end else if (w_rd_fire) begin
          if (w_rd_final) begin
            w_rd_valid_nxt = 1'b0;
            w_rd_last_nxt  = 1'b0;
            w_phase_nxt    = PhDone;
          end else begin
            w_rd_ptr_nxt  = r_rd_ptr + 1'b1;
            w_fetch_ptr   = r_rd_ptr + 1'b1;
            w_rd_fetch    = 1'b1;
            w_rd_last_nxt = ((32'(r_rd_ptr) + 32'd1) == OUT_LEN - 1);
          end
        end
      end
      PhDone: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase    <= PhLoad;
      r_proc_rst <= 1'b1;
      r_ld_ready <= 1'b0;
      r_ld_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= 8'h00;
      r_dm_rdata <= 8'h00;
    end else begin
      r_phase    <= w_phase_nxt;
      r_proc_rst <= w_proc_rst_nxt;
      r_ld_ready <= w_ld_ready_nxt;
      r_ld_ptr   <= w_ld_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_last  <= w_rd_last_nxt;
      if (r_phase == PhRun) begin
        r_dm_rdata <= w_dm_in_range ? r_mem[bus.dm_addr] : 8'h00;
      end
      if (w_rd_fetch) begin
        r_rd_data <= r_mem[w_fetch_addr];
      end
    end
  end

  // Array is deliberately left out of reset so contents survive a restart.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((OUT_BASE + OUT_LEN <= DEPTH) && (LOAD_LEN <= DEPTH))
        else $error("dm_responder: LOAD_LEN or result region exceeds DEPTH");
    end
  end

  assign bus.dm_rdata = r_dm_rdata;
  assign bus.proc_rst = r_proc_rst;
  assign bus.ld_ready = r_ld_ready;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_last  = r_rd_last;
  assign bus.phase    = r_phase;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: load/reset vector table, then scoreboard-checked
// DM reads and result dumps including backpressure and mid-dump reset.
module tb_dm_responder;

  logic clk;
  logic rst;

  dm_responder_if #(.ADDR_W(4)) bus ();

  dm_responder #(
    .ADDR_W  (4),
    .LOAD_LEN(4),
    .OUT_BASE(8),
    .OUT_LEN (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       proc_done;
    logic       dm_we;
    logic [3:0] dm_addr;
    logic [7:0] dm_wdata;
    logic [1:0] exp_phase;
    logic       exp_proc_rst;
    logic       exp_ld_ready;
  } vec_t;

  typedef struct packed {
    logic       known;
    logic [7:0] val;
  } sb_t;

  int n_pass;
  int n_checks;

  logic [7:0] m_mem [16];
  logic       m_known [16];
  sb_t        sb_rd [$];
  logic [7:0] q_dump [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  // DM access in RUN; expected read data is queued as the request is driven.
  task automatic dm_access(input logic [3:0] a, input logic we, input logic [7:0] d);
    sb_t e;
    bus.dm_addr  = a;
    bus.dm_we    = we;
    bus.dm_wdata = d;
    e.known = m_known[a];
    e.val   = m_mem[a];
    sb_rd.push_back(e);
    if (we) begin
      m_mem[a]   = d;
      m_known[a] = 1'b1;
    end
    step();
    bus.dm_we = 1'b0;
    e = sb_rd.pop_front();
    if (e.known) chk($sformatf("dm_rdata@%0d", a), 32'(bus.dm_rdata), 32'(e.val));
  endtask

  task automatic load_byte(input logic [7:0] d, input logic [3:0] a);
    int n = 0;
    while (bus.ld_ready !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("ld_ready_wait", 32'(bus.ld_ready), 32'd1);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    step();
    bus.ld_valid = 1'b0;
    m_mem[a]   = d;
    m_known[a] = 1'b1;
  endtask

  // Raise proc_done (optionally with a same-cycle write) and check the 2-cycle
  // latency to the first result byte.
  task automatic start_dump(input int hold, input logic we, input logic [3:0] a,
                            input logic [7:0] d, output logic [7:0] rd_before);
    rd_before     = m_mem[a];
    bus.proc_done = 1'b1;
    bus.dm_we     = we;
    bus.dm_addr   = a;
    bus.dm_wdata  = d;
    if (we) m_mem[a] = d;
    q_dump.delete();
    q_dump.push_back(m_mem[8]);
    q_dump.push_back(m_mem[9]);
    step();
    chk("dump_phase", 32'(bus.phase), 32'd2);
    chk("dump_proc_rst", 32'(bus.proc_rst), 32'd1);
    chk("dump_rd_valid_early", 32'(bus.rd_valid), 32'd0);
    bus.proc_done = (hold > 1);
    bus.dm_we     = 1'b1;
    bus.dm_addr   = 4'd8;
    bus.dm_wdata  = 8'h00;
    step();
    bus.proc_done = 1'b0;
    bus.dm_we     = 1'b0;
    chk("dump_rd_valid_lat", 32'(bus.rd_valid), 32'd1);
    chk("dump_phase_hold", 32'(bus.phase), 32'd2);
  endtask

  task automatic run_dump(input int stalls);
    int budget = 40;
    int st = 0;
    while (q_dump.size() > 0 && budget > 0) begin
      if (bus.rd_valid) begin
        chk("rd_data", 32'(bus.rd_data), 32'(q_dump[0]));
        chk("rd_last", 32'(bus.rd_last), 32'(q_dump.size() == 1));
        if (st < stalls) begin
          bus.rd_ready = 1'b0;
          st++;
        end else begin
          bus.rd_ready = 1'b1;
          void'(q_dump.pop_front());
        end
      end else begin
        bus.rd_ready = 1'b0;
      end
      step();
      budget--;
    end
    bus.rd_ready = 1'b0;
    chk("dump_drained", 32'(q_dump.size()), 32'd0);
    chk("done_phase", 32'(bus.phase), 32'd3);
    chk("done_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("done_rd_last", 32'(bus.rd_last), 32'd0);
    chk("done_proc_rst", 32'(bus.proc_rst), 32'd1);
  endtask

  vec_t vecs [9];

  initial begin
    logic [7:0] hold_val;
    n_pass   = 0;
    n_checks = 0;
    for (int i = 0; i < 16; i++) begin
      m_mem[i]   = 8'h00;
      m_known[i] = 1'b0;
    end
    rst           = 1'b1;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.dm_we     = 1'b0;
    bus.proc_done = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.rd_ready  = 1'b0;

    //          rst ldv data  pd we adr  wdata  phase prst ldr
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 2'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 4'h0, 8'h00, 2'd0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 4'h0, 8'h00, 2'd0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 4'h0, 8'hFF, 2'd0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 4'h0, 8'h00, 2'd1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 4'h2, 8'h00, 2'd1, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      rst           = vecs[i].rst;
      bus.ld_valid  = vecs[i].ld_valid;
      bus.ld_data   = vecs[i].ld_data;
      bus.proc_done = vecs[i].proc_done;
      bus.dm_we     = vecs[i].dm_we;
      bus.dm_addr   = vecs[i].dm_addr;
      bus.dm_wdata  = vecs[i].dm_wdata;
      step();
      chk($sformatf("v%0d_phase", i), 32'(bus.phase), 32'(vecs[i].exp_phase));
      chk($sformatf("v%0d_proc_rst", i), 32'(bus.proc_rst), 32'(vecs[i].exp_proc_rst));
      chk($sformatf("v%0d_ld_ready", i), 32'(bus.ld_ready), 32'(vecs[i].exp_ld_ready));
      if (i == 0) begin
        chk("rst_dm_rdata", 32'(bus.dm_rdata), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_rd_last", 32'(bus.rd_last), 32'd0);
      end
    end
    bus.ld_valid  = 1'b0;
    bus.proc_done = 1'b0;
    m_mem[0] = 8'h11; m_mem[1] = 8'h22; m_mem[2] = 8'h33; m_mem[3] = 8'h44;
    for (int i = 0; i < 4; i++) m_known[i] = 1'b1;

    // RUN: loaded contents, write/readback, read-before-write on one address.
    for (int i = 0; i < 4; i++) dm_access(4'(i), 1'b0, 8'h00);
    dm_access(4'd8, 1'b1, 8'hA5);
    dm_access(4'd8, 1'b0, 8'h00);
    dm_access(4'd9, 1'b1, 8'h00);
    dm_access(4'd9, 1'b1, 8'h5A);
    dm_access(4'd9, 1'b0, 8'h00);
    dm_access(4'd4, 1'b1, 8'h77);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h99;
    step();
    step();
    bus.ld_valid = 1'b0;
    chk("run_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("run_phase", 32'(bus.phase), 32'd1);
    dm_access(4'd4, 1'b0, 8'h00);

    // Dump with proc_done held 2 cycles, same-cycle write, 3-cycle stall.
    start_dump(2, 1'b1, 4'd9, 8'h6B, hold_val);
    chk("dump_dm_rdata_hold", 32'(bus.dm_rdata), 32'(hold_val));
    run_dump(3);

    // DONE ignores everything.
    bus.dm_we     = 1'b1;
    bus.dm_addr   = 4'd9;
    bus.dm_wdata  = 8'hEE;
    bus.ld_valid  = 1'b1;
    bus.proc_done = 1'b1;
    bus.rd_ready  = 1'b1;
    step();
    step();
    bus.dm_we     = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.proc_done = 1'b0;
    bus.rd_ready  = 1'b0;
    chk("done_stay_phase", 32'(bus.phase), 32'd3);
    chk("done_stay_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("done_stay_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Restart, reload, and reset in the middle of a stalled dump.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_phase", 32'(bus.phase), 32'd0);
    for (int i = 0; i < 4; i++) load_byte(8'(i + 1), 4'(i));
    chk("reload_phase", 32'(bus.phase), 32'd1);
    chk("reload_proc_rst", 32'(bus.proc_rst), 32'd0);
    dm_access(4'd0, 1'b0, 8'h00);
    start_dump(1, 1'b0, 4'd0, 8'h00, hold_val);
    chk("stall_rd_data", 32'(bus.rd_data), 32'(q_dump[0]));
    bus.rd_ready = 1'b0;
    step();
    chk("stall_rd_data_held", 32'(bus.rd_data), 32'(q_dump[0]));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("middump_rst_phase", 32'(bus.phase), 32'd0);
    chk("middump_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("middump_rst_proc_rst", 32'(bus.proc_rst), 32'd1);
    chk("middump_rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("middump_rst_rd_last", 32'(bus.rd_last), 32'd0);

    // Result region must have survived both resets.
    for (int i = 0; i < 4; i++) load_byte(8'(8'h40 + i), 4'(i));
    chk("reload2_phase", 32'(bus.phase), 32'd1);
    start_dump(1, 1'b0, 4'd0, 8'h00, hold_val);
    run_dump(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory end of the processor's DM port: services the processor's address / write-data / write-strobe requests and returns read data with one cycle of latency.
- Also owns the host side of the down-sampling flow:
  - streams the source image into memory while holding the processor in reset;
  - releases the processor to run;
  - streams the down-sampled result back out once the processor signals completion.

Parameters:
- ADDR_W, 18, DM address width; matches the processor's DM address bus.
- DEPTH, 2**ADDR_W, number of 8-bit memory locations.
- LOAD_LEN, 65536, number of image bytes loaded at address 0 upward.
- OUT_BASE, 65536, first address of the result region.
- OUT_LEN, 16384, number of result bytes streamed out.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- dm_addr  in  ADDR_W  processor DM address.
- dm_wdata  in  8  processor write data.
- dm_we  in  1  processor write strobe (processor "memory" output).
- dm_rdata  out  8  registered read data to the processor.
- proc_done  in  1  processor completion flag (processor "data_out" output).
- proc_rst  out  1  holds the processor in reset; high in every phase except RUN.
- ld_valid  in  1  host load byte valid.
- ld_data  in  8  host load byte.
- ld_ready  out  1  module accepts a load byte.
- rd_valid  out  1  result byte valid.
- rd_data  out  8  result byte.
- rd_last  out  1  marks the final result byte.
- rd_ready  in  1  host accepts the result byte.
- phase  out  2  current state: LOAD=0, RUN=1, DUMP=2, DONE=3.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - phase=LOAD, proc_rst=1, ld_ready=0, dm_rdata=0, rd_valid=0, rd_data=0, rd_last=0.
  - Load and dump pointers are cleared.
  - The memory array is not cleared.
  - Reset in any phase, including mid-load or mid-dump, aborts immediately; in-flight handshakes are dropped.
- LOAD:
  - ld_ready=1 from the first edge after rst is deasserted.
  - Each cycle with ld_valid&&ld_ready: mem[ld_ptr]=ld_data, then ld_ptr+1.
  - On acceptance of byte LOAD_LEN-1, at that same edge: phase->RUN, ld_ready->0, proc_rst->0.
  - dm_we is ignored in LOAD; proc_done is ignored.
- RUN:
  - dm_rdata <= mem[dm_addr] every cycle, giving 1-cycle read latency.
  - If dm_we=1, mem[dm_addr] <= dm_wdata.
  - Read-during-write to the same address returns the old data (read-before-write).
  - dm_addr>=DEPTH: the read returns 0 and the write is dropped.
  - ld_valid is ignored, with ld_ready=0.
  - proc_done sampled 1: phase->DUMP and proc_rst->1 at the next edge. A write presented in that same cycle is still performed.
- DUMP:
  - dm_we is ignored and dm_rdata holds its last value.
  - Reads come from mem[OUT_BASE+rd_ptr].
  - The first rd_valid=1 appears 2 cycles after proc_done is sampled (1-cycle memory read).
  - While rd_valid&&!rd_ready: rd_data and rd_last hold stable.
  - On handshake: the next byte is presented on the following cycle (the read is prefetched so back-to-back handshakes sustain 1 byte/cycle).
  - rd_last=1 exactly with byte OUT_LEN-1.
  - After the final handshake: rd_valid=0, rd_last=0, phase->DONE.
- DONE:
  - All inputs are ignored; outputs hold proc_rst=1, ld_ready=0, rd_valid=0.
  - Only rst leaves DONE.
- Boundary rules:
  - Pointer widths are ADDR_W bits and do not wrap within one run.
  - OUT_BASE+OUT_LEN<=DEPTH and LOAD_LEN<=DEPTH are required; a simulation assertion fires otherwise.
  - proc_done held high for several cycles causes a single transition only.

Test Plan:
- Parameters for the bench: ADDR_W=4, LOAD_LEN=4, OUT_BASE=8, OUT_LEN=2.
- Reset/load:
  - Stimulus: rst 2 cycles, then load bytes 0x11,0x22,0x33,0x44 with ld_valid stalled for 1 cycle between bytes 2 and 3.
  - Required: ld_ready=0 during rst; phase goes 0->1 on the 4th acceptance; proc_rst falls at the same edge; mem[0..3]=11,22,33,44.
- RUN read/write:
  - Stimulus: dm_addr=2 with dm_we=0; next cycle dm_addr=8, dm_we=1, dm_wdata=0xA5; next cycle read addr 8.
  - Required: dm_rdata=0x33 one cycle after the addr-2 request; 0xA5 after the addr-8 read.
- Same-address read/write:
  - Stimulus: dm_addr=9, dm_we=1, dm_wdata=0x5A while mem[9]=0x00.
  - Required: dm_rdata=0x00 next cycle; 0x5A on a subsequent read.
- Dump with backpressure:
  - Stimulus: pulse proc_done; hold rd_ready=0 for 3 cycles, then 1.
  - Required: rd_valid rises 2 cycles after proc_done; rd_data=0xA5 held stable during the stall; then 0x5A with rd_last=1; phase=3 afterwards.
- Ignored inputs:
  - Stimulus: ld_valid=1 in RUN; dm_we=1 in DUMP/DONE; proc_done=1 in LOAD.
  - Required: no memory change and no phase change.
- Mid-dump reset:
  - Stimulus: rst during a DUMP stall.
  - Required: next cycle phase=0, rd_valid=0, proc_rst=1; memory contents retained (reload then redump gives the same values).
